// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and the
// baud-derived watchdog limits.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_BUSY   = 2'd2
   } arb_state_e;

   function automatic int bit_cycles(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int launch_limit(input int bit_cyc);
      return 2 * bit_cyc;
   endfunction

   function automatic int busy_limit(input int frame_w, input int bit_cyc);
      return (frame_w + 2) * bit_cyc;
   endfunction

   // Round-robin search origin: one past the last owner, wrapping to 0.
   function automatic int rr_start(input int last, input int num_req);
      return (last + 1 >= num_req) ? 0 : last + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester, transmitter and status signals of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ     = 4,
   parameter int FRAME_WIDTH = 10
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]             req_valid;
   logic [0:NUM_REQ*FRAME_WIDTH-1] req_data;
   logic [NUM_REQ-1:0]             req_ready;
   logic                           uart_tx_done;
   logic                           uart_tx_en;
   logic [0:FRAME_WIDTH-1]         uart_tx_din;
   logic [IDX_W-1:0]               grant_id;
   logic                           busy;
   logic                           tx_complete;
   logic                           tx_error;

   modport master (
      input  req_valid, req_data, uart_tx_done,
      output req_ready, uart_tx_en, uart_tx_din, grant_id, busy, tx_complete, tx_error
   );

   modport slave (
      output req_valid, req_data, uart_tx_done,
      input  req_ready, uart_tx_en, uart_tx_din, grant_id, busy, tx_complete, tx_error
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so the search
// origin sits at bit 0, take the lowest set bit, then rotate the index back.
module uart_rr_picker
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic [NUM_REQ-1:0]         grant_onehot,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       any
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = {{(NUM_REQ - 1){1'b0}}, 1'b1};

   logic [IDX_W-1:0]     start_s;
   logic [IDX_W-1:0]     off_s;
   logic [2*NUM_REQ-1:0] wide_s;
   logic [2*NUM_REQ-1:0] shifted_s;
   logic [NUM_REQ-1:0]   rot_s;
   logic [IDX_W:0]       sum_s;

   assign any = |req_valid;

   // Rotate, priority-encode from the origin, and map back to a requester index.
   always_comb begin
      start_s   = IDX_W'(rr_start(int'(last_grant), NUM_REQ));
      wide_s    = {req_valid, req_valid};
      shifted_s = wide_s >> start_s;
      rot_s     = shifted_s[NUM_REQ-1:0];
      off_s     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         off_s = rot_s[i] ? IDX_W'(i) : off_s;
      end
      sum_s        = {1'b0, start_s} + {1'b0, off_s};
      grant_idx    = (sum_s >= NUM_REQ_W) ? IDX_W'(sum_s - NUM_REQ_W) : sum_s[IDX_W-1:0];
      grant_onehot = any ? (ONE_HOT_LSB << grant_idx) : '0;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ requesters,
// with a launch/frame watchdog that recovers from a transmitter that never answers.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int SYS_CLK_FREQ = 200_000_000,
   parameter int BAUD_RATE    = 19200,
   parameter int FRAME_WIDTH  = 10,
   parameter int NUM_REQ      = 4
) (
   input  logic              sys_clk,
   input  logic              reset_n,
   uart_tx_arbiter_if.master bus
);
   localparam int IDX_W        = $clog2(NUM_REQ);
   localparam int BIT_CYCLES   = bit_cycles(SYS_CLK_FREQ, BAUD_RATE);
   localparam int LAUNCH_LIMIT = launch_limit(BIT_CYCLES);
   localparam int BUSY_LIMIT   = busy_limit(FRAME_WIDTH, BIT_CYCLES);
   localparam int WD_W         = $clog2(BUSY_LIMIT + 1);

   localparam logic [WD_W-1:0]  WD_LAUNCH_MAX = WD_W'(LAUNCH_LIMIT);
   localparam logic [WD_W-1:0]  WD_BUSY_MAX   = WD_W'(BUSY_LIMIT);
   localparam logic [WD_W-1:0]  WD_ONE        = WD_W'(1);
   localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_REQ - 1);

   arb_state_e             state_r;
   arb_state_e             state_nxt_s;
   logic [WD_W-1:0]        wd_r;
   logic [IDX_W-1:0]       last_grant_r;
   logic [IDX_W-1:0]       grant_id_r;
   logic [0:FRAME_WIDTH-1] din_r;
   logic                   tx_en_r;
   logic                   tx_complete_r;
   logic                   tx_error_r;

   logic [NUM_REQ-1:0]     pick_onehot_s;
   logic [IDX_W-1:0]       pick_idx_s;
   logic                   pick_any_s;
   logic [0:FRAME_WIDTH-1] sel_data_s;
   logic                   accept_s;
   logic                   complete_s;
   logic                   timeout_s;

   uart_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req_valid    (bus.req_valid),
      .last_grant   (last_grant_r),
      .grant_onehot (pick_onehot_s),
      .grant_idx    (pick_idx_s),
      .any          (pick_any_s)
   );

   // Frame of the winning requester.
   always_comb begin
      sel_data_s = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sel_data_s = (pick_idx_s == IDX_W'(k)) ? bus.req_data[k*FRAME_WIDTH +: FRAME_WIDTH]
                                                : sel_data_s;
      end
   end

   // Next-state decode; a launch that sees uart_tx_done drop wins a tie with the watchdog.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      complete_s  = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (reset_n && bus.uart_tx_done && pick_any_s) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_LAUNCH;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            if (!bus.uart_tx_done) begin
               state_nxt_s = ST_BUSY;
            end else if (wd_r >= WD_LAUNCH_MAX) begin
               timeout_s   = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_LAUNCH;
            end
         end
         ST_BUSY: begin
            if (bus.uart_tx_done) begin
               complete_s  = 1'b1;
               state_nxt_s = ST_IDLE;
            end else if (wd_r >= WD_BUSY_MAX) begin
               timeout_s   = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register and watchdog, which restarts on each state change and saturates.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         wd_r    <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (state_nxt_s != state_r) begin
            wd_r <= '0;
         end else if (wd_r != WD_BUSY_MAX) begin
            wd_r <= wd_r + WD_ONE;
         end else begin
            wd_r <= wd_r;
         end
      end
   end

   // Launch datapath; last_grant advances on every accept, even if the frame later fails.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         din_r        <= '0;
         grant_id_r   <= '0;
         last_grant_r <= LAST_IDX;
         tx_en_r      <= 1'b0;
      end else begin
         tx_en_r <= (state_nxt_s == ST_LAUNCH);
         if (accept_s) begin
            din_r        <= sel_data_s;
            grant_id_r   <= pick_idx_s;
            last_grant_r <= pick_idx_s;
         end
      end
   end

   // One-cycle completion and error pulses, high in the first cycle back in IDLE.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_complete_r <= 1'b0;
         tx_error_r    <= 1'b0;
      end else begin
         tx_complete_r <= complete_s;
         tx_error_r    <= timeout_s;
      end
   end

   assign bus.req_ready   = {NUM_REQ{accept_s}} & pick_onehot_s;
   assign bus.uart_tx_en  = tx_en_r;
   assign bus.uart_tx_din = din_r;
   assign bus.grant_id    = grant_id_r;
   assign bus.busy        = (state_r != ST_IDLE);
   assign bus.tx_complete = tx_complete_r;
   assign bus.tx_error    = tx_error_r;

endmodule
